// File: rtl/mmu_tlb.sv
// Fully associative TLB with a single-request page-table walker.
// One translation in flight; the result is held until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request; lookup happens in the acceptance cycle
// WALK  | miss outstanding, pt_req_valid held until the page-table answers
// RESP  | rsp_valid high, rsp_* held until rsp_ready
module mmu_tlb #(
  parameter int VA_WIDTH    = 32,
  parameter int PA_WIDTH    = 32,
  parameter int PAGE_BITS   = 12,
  parameter int TLB_ENTRIES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [VA_WIDTH-1:0]           req_vaddr,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [PA_WIDTH-1:0]           rsp_paddr,
  output logic                          rsp_fault,
  output logic                          rsp_hit,
  output logic                          pt_req_valid,
  output logic [VA_WIDTH-PAGE_BITS-1:0] pt_req_vpn,
  input  logic                          pt_rsp_valid,
  input  logic [PA_WIDTH-PAGE_BITS-1:0] pt_rsp_ppn,
  input  logic                          pt_rsp_fault,
  input  logic                          flush
);

  localparam int VPN_W = VA_WIDTH - PAGE_BITS;
  localparam int PPN_W = PA_WIDTH - PAGE_BITS;
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

  state_t                 state;
  logic [TLB_ENTRIES-1:0] valid;
  logic [VPN_W-1:0]       tag_tab [TLB_ENTRIES];
  logic [PPN_W-1:0]       ppn_tab [TLB_ENTRIES];
  logic [IDX_W-1:0]       victim;
  logic [VPN_W-1:0]       vpn_q;
  logic [PAGE_BITS-1:0]   off_q;

  logic [VPN_W-1:0]       req_vpn;
  logic [PAGE_BITS-1:0]   req_off;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       fill_idx;
  logic                   fill_en;

  assign req_vpn      = req_vaddr[VA_WIDTH-1:PAGE_BITS];
  assign req_off      = req_vaddr[PAGE_BITS-1:0];
  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign pt_req_valid = (state == WALK);
  assign pt_req_vpn   = vpn_q;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid[i] && (tag_tab[i] == req_vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Descending scan so the lowest-index free slot is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign fill_idx = free_found ? free_idx : victim;
  // A flush landing on the fill edge suppresses the fill entirely.
  assign fill_en  = (state == WALK) && pt_rsp_valid && !pt_rsp_fault && !flush;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_tab[fill_idx] <= vpn_q;
      ppn_tab[fill_idx] <= pt_rsp_ppn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      victim    <= '0;
      vpn_q     <= '0;
      off_q     <= '0;
      rsp_paddr <= '0;
      rsp_fault <= 1'b0;
      rsp_hit   <= 1'b0;
    end else begin
      if (flush) begin
        valid <= '0;
      end else if (fill_en) begin
        valid[fill_idx] <= 1'b1;
      end
      if (fill_en && !free_found) begin
        victim <= victim + 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            vpn_q <= req_vpn;
            off_q <= req_off;
            if (hit) begin
              rsp_paddr <= {ppn_tab[hit_idx], req_off};
              rsp_hit   <= 1'b1;
              rsp_fault <= 1'b0;
              state     <= RESP;
            end else begin
              state <= WALK;
            end
          end
        end
        WALK: begin
          if (pt_rsp_valid) begin
            rsp_hit <= 1'b0;
            if (pt_rsp_fault) begin
              rsp_paddr <= '0;
              rsp_fault <= 1'b1;
            end else begin
              rsp_paddr <= {pt_rsp_ppn, off_q};
              rsp_fault <= 1'b0;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: vector table of translations plus hand-built
// sequences for flush/lookup overlap and reset in the middle of a walk.
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vaddr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_paddr;
  logic        rsp_fault;
  logic        rsp_hit;
  logic        pt_req_valid;
  logic [19:0] pt_req_vpn;
  logic        pt_rsp_valid = 1'b0;
  logic [19:0] pt_rsp_ppn = '0;
  logic        pt_rsp_fault = 1'b0;
  logic        flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  mmu_tlb #(.VA_WIDTH(32), .PA_WIDTH(32), .PAGE_BITS(12), .TLB_ENTRIES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
    .rsp_fault(rsp_fault), .rsp_hit(rsp_hit),
    .pt_req_valid(pt_req_valid), .pt_req_vpn(pt_req_vpn),
    .pt_rsp_valid(pt_rsp_valid), .pt_rsp_ppn(pt_rsp_ppn), .pt_rsp_fault(pt_rsp_fault),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic        flush_fill;
    logic [31:0] vaddr;
    logic        walk;
    logic [19:0] ppn;
    logic        pt_fault;
    logic [31:0] exp_paddr;
    logic        exp_hit;
    logic        exp_fault;
    int          stall;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mkv(logic rb, logic ff, logic [31:0] va, logic wk,
                               logic [19:0] pp, logic pf, logic [31:0] pa,
                               logic eh, logic ef, int st);
    vec_t v;
    v.rst_before = rb; v.flush_fill = ff; v.vaddr = va; v.walk = wk;
    v.ppn = pp; v.pt_fault = pf; v.exp_paddr = pa; v.exp_hit = eh;
    v.exp_fault = ef; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset pt_req_valid", {31'b0, pt_req_valid}, 32'd0);
    chk("reset rsp_paddr", rsp_paddr, 32'd0);
    chk("reset rsp_hit", {31'b0, rsp_hit}, 32'd0);
    chk("reset rsp_fault", {31'b0, rsp_fault}, 32'd0);
  endtask

  task automatic do_xlate(input vec_t v);
    if (v.rst_before) do_reset();
    chk("req_ready before request", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_vaddr = v.vaddr;
    tick();
    req_valid = 1'b0;
    if (v.walk) begin
      chk("walk pt_req_valid", {31'b0, pt_req_valid}, 32'd1);
      chk("walk pt_req_vpn", {12'b0, pt_req_vpn}, {12'b0, v.vaddr[31:12]});
      chk("walk rsp_valid low", {31'b0, rsp_valid}, 32'd0);
      tick();
      tick();
      chk("walk pt_req_valid held", {31'b0, pt_req_valid}, 32'd1);
      pt_rsp_valid = 1'b1;
      pt_rsp_ppn   = v.ppn;
      pt_rsp_fault = v.pt_fault;
      flush        = v.flush_fill;
      tick();
      pt_rsp_valid = 1'b0;
      pt_rsp_fault = 1'b0;
      flush        = 1'b0;
    end
    chk("pt_req_valid low in resp", {31'b0, pt_req_valid}, 32'd0);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_paddr", rsp_paddr, v.exp_paddr);
    chk("rsp_hit", {31'b0, rsp_hit}, {31'b0, v.exp_hit});
    chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, v.exp_fault});
    for (int s = 0; s < v.stall; s++) begin
      req_valid = 1'b1;
      req_vaddr = 32'hFFFF_F000;
      tick();
      chk("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall rsp_paddr", rsp_paddr, v.exp_paddr);
      chk("stall rsp_hit", {31'b0, rsp_hit}, {31'b0, v.exp_hit});
      chk("stall req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("after resp rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("after resp req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    // cold miss, hit, faults
    vecs[0]  = mkv(1, 0, 32'h0000_3ABC, 1, 20'h00041, 0, 32'h0004_1ABC, 0, 0, 0);
    vecs[1]  = mkv(0, 0, 32'h0000_3123, 0, 20'h0,     0, 32'h0004_1123, 1, 0, 0);
    vecs[2]  = mkv(0, 0, 32'h0000_7000, 1, 20'h00077, 1, 32'h0000_0000, 0, 1, 0);
    vecs[3]  = mkv(0, 0, 32'h0000_7000, 1, 20'h00077, 1, 32'h0000_0000, 0, 1, 0);
    // replacement: fill 1..4 into slots 0..3, then 5 evicts VPN1 (slot 0)
    vecs[4]  = mkv(1, 0, 32'h0000_1000, 1, 20'h00011, 0, 32'h0001_1000, 0, 0, 0);
    vecs[5]  = mkv(0, 0, 32'h0000_2004, 1, 20'h00022, 0, 32'h0002_2004, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 32'h0000_3008, 1, 20'h00033, 0, 32'h0003_3008, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 32'h0000_400C, 1, 20'h00044, 0, 32'h0004_400C, 0, 0, 0);
    vecs[8]  = mkv(0, 0, 32'h0000_5010, 1, 20'h00055, 0, 32'h0005_5010, 0, 0, 0);
    vecs[9]  = mkv(0, 0, 32'h0000_2FFF, 0, 20'h0,     0, 32'h0002_2FFF, 1, 0, 0);
    vecs[10] = mkv(0, 0, 32'h0000_3001, 0, 20'h0,     0, 32'h0003_3001, 1, 0, 0);
    vecs[11] = mkv(0, 0, 32'h0000_4002, 0, 20'h0,     0, 32'h0004_4002, 1, 0, 0);
    vecs[12] = mkv(0, 0, 32'h0000_5003, 0, 20'h0,     0, 32'h0005_5003, 1, 0, 0);
    // VPN1 walks again and lands on slot 1 (evicting VPN2), then VPN2 evicts VPN3
    vecs[13] = mkv(0, 0, 32'h0000_1234, 1, 20'h00066, 0, 32'h0006_6234, 0, 0, 0);
    vecs[14] = mkv(0, 0, 32'h0000_2000, 1, 20'h00077, 0, 32'h0007_7000, 0, 0, 0);
    vecs[15] = mkv(0, 0, 32'h0000_1ABC, 0, 20'h0,     0, 32'h0006_6ABC, 1, 0, 0);
    vecs[16] = mkv(0, 0, 32'h0000_3000, 1, 20'h00088, 0, 32'h0008_8000, 0, 0, 0);
    // backpressure on a hit, then flush on the fill edge
    vecs[17] = mkv(0, 0, 32'h0000_5ABC, 0, 20'h0,     0, 32'h0005_5ABC, 1, 0, 5);
    vecs[18] = mkv(0, 1, 32'h0000_9123, 1, 20'h00099, 0, 32'h0009_9123, 0, 0, 0);
    vecs[19] = mkv(0, 0, 32'h0000_9000, 1, 20'h000A9, 0, 32'h000A_9000, 0, 0, 3);

    do_reset();
    for (int i = 0; i < NV; i++) do_xlate(vecs[i]);

    // lookup coincident with flush sees the old contents, later lookup misses
    req_valid = 1'b1;
    req_vaddr = 32'h0000_9555;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush+lookup rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("flush+lookup rsp_hit", {31'b0, rsp_hit}, 32'd1);
    chk("flush+lookup rsp_paddr", rsp_paddr, 32'h000A_9555);
    chk("flush+lookup pt_req_valid", {31'b0, pt_req_valid}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    do_xlate(mkv(0, 0, 32'h0000_9555, 1, 20'h000B9, 0, 32'h000B_9555, 0, 0, 0));
    do_xlate(mkv(0, 0, 32'h0000_5000, 1, 20'h0005A, 0, 32'h0005_A000, 0, 0, 0));

    // page-table response outside WALK is ignored
    pt_rsp_valid = 1'b1;
    pt_rsp_ppn   = 20'h12345;
    tick();
    pt_rsp_valid = 1'b0;
    chk("idle pt_rsp rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle pt_rsp req_ready", {31'b0, req_ready}, 32'd1);

    // reset in the middle of a walk
    req_valid = 1'b1;
    req_vaddr = 32'h0000_C000;
    tick();
    req_valid = 1'b0;
    chk("midwalk pt_req_valid", {31'b0, pt_req_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post-rst pt_req_valid", {31'b0, pt_req_valid}, 32'd0);
    chk("post-rst req_ready", {31'b0, req_ready}, 32'd1);
    pt_rsp_valid = 1'b1;
    pt_rsp_ppn   = 20'h000CC;
    tick();
    pt_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late pt_rsp rsp_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    // reset also dropped every entry: VPN5 walks again
    do_xlate(mkv(0, 0, 32'h0000_5000, 1, 20'h000CC, 0, 32'h000C_C000, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
